// File: rtl/projective_to_affine.sv
// Ed25519 projective (X:Y:Z) -> affine (X/Z, Y/Z) converter: Fermat inversion Z^(P-2) on one bit-serial modular multiplier.
// Optional macro P2A_ZERO_CHECK_EN: Z=0 bypasses the exponentiation and flags zero_z.
module projective_to_affine #(
    parameter int WIDTH = 256,
    parameter logic [WIDTH-1:0] P = {1'b0, {(WIDTH-6){1'b1}}, 5'b01101}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             zero_z
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds valid and data stable until then, and ready never depends on valid.

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] E = P - WIDTH'(2);

    typedef enum logic [2:0] {IDLE, LOAD, EXP, MX, MY, DONE} state_e;
    state_e state_q, state_d;

    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, r_q, r_d;
    logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, xo_q, xo_d, yo_q, yo_d;
    logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d, k_q, k_d;
    logic             mul_q, mul_d, ov_q, ov_d;
`ifdef P2A_ZERO_CHECK_EN
    logic             zero_q, zero_d, zo_q, zo_d;
`endif

    logic [WIDTH-1:0] a_sel, b_sel, a_cur, b_cur, acc_cur, step_res;
    logic [WIDTH:0]   dbl, dbl_red, sum, sum_red;
    logic             first, last;

    // One shift-add step per cycle; step 0 of each product takes fresh operands.
    always_comb begin
        a_sel = r_q;
        b_sel = r_q;
        case (state_q)
            EXP:     b_sel = mul_q ? z_q : r_q;
            MX:      a_sel = x_q;
            MY:      a_sel = y_q;
            default: ;
        endcase
        first   = (cnt_q == '0);
        last    = (cnt_q == '1);
        a_cur   = first ? a_sel : a_q;
        b_cur   = first ? b_sel : b_q;
        acc_cur = first ? '0 : acc_q;
        dbl     = {acc_cur, 1'b0};
        dbl_red = (dbl >= {1'b0, P}) ? dbl - {1'b0, P} : dbl;
        sum     = dbl_red + (b_cur[WIDTH-1] ? {1'b0, a_cur} : '0);
        sum_red = (sum >= {1'b0, P}) ? sum - {1'b0, P} : sum;
        step_res = sum_red[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        x_d = x_q;   y_d = y_q;   z_d = z_q;   r_d = r_q;
        xr_d = xr_q; yr_d = yr_q; xo_d = xo_q; yo_d = yo_q;
        acc_d = acc_q; a_d = a_q; b_d = b_q;
        cnt_d = cnt_q; k_d = k_q; mul_d = mul_q; ov_d = ov_q;
`ifdef P2A_ZERO_CHECK_EN
        zero_d = zero_q;
        zo_d   = zo_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d = x_in;
                    y_d = y_in;
                    z_d = z_in;
                    xr_d = '0;
                    yr_d = '0;
`ifdef P2A_ZERO_CHECK_EN
                    zero_d = (z_in == '0);
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                r_d   = WIDTH'(1);
                k_d   = CW'(WIDTH - 2);
                mul_d = 1'b0;
                cnt_d = '0;
                state_d = EXP;
`ifdef P2A_ZERO_CHECK_EN
                if (zero_q) state_d = DONE;
`endif
            end
            EXP, MX, MY: begin
                acc_d = step_res;
                a_d   = a_cur;
                b_d   = b_cur << 1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    if (state_q == EXP) begin
                        r_d = step_res;
                        // A square is followed by a multiply only when the exponent bit is set.
                        if (!mul_q && E[k_q]) begin
                            mul_d = 1'b1;
                        end else begin
                            mul_d = 1'b0;
                            if (k_q == '0) state_d = MX;
                            else           k_d = k_q - CW'(1);
                        end
                    end else if (state_q == MX) begin
                        xr_d = step_res;
                        state_d = MY;
                    end else begin
                        yr_d = step_res;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!ov_q) begin
                    xo_d = xr_q;
                    yo_d = yr_q;
                    ov_d = 1'b1;
`ifdef P2A_ZERO_CHECK_EN
                    zo_d = zero_q;
`endif
                end else if (out_ready) begin
                    ov_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q <= '0;  y_q <= '0;  z_q <= '0;  r_q <= '0;
            xr_q <= '0; yr_q <= '0; xo_q <= '0; yo_q <= '0;
            acc_q <= '0; a_q <= '0; b_q <= '0;
            cnt_q <= '0; k_q <= '0; mul_q <= 1'b0; ov_q <= 1'b0;
`ifdef P2A_ZERO_CHECK_EN
            zero_q <= 1'b0;
            zo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q <= x_d;   y_q <= y_d;   z_q <= z_d;   r_q <= r_d;
            xr_q <= xr_d; yr_q <= yr_d; xo_q <= xo_d; yo_q <= yo_d;
            acc_q <= acc_d; a_q <= a_d; b_q <= b_d;
            cnt_q <= cnt_d; k_q <= k_d; mul_q <= mul_d; ov_q <= ov_d;
`ifdef P2A_ZERO_CHECK_EN
            zero_q <= zero_d;
            zo_q   <= zo_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign x_out     = xo_q;
    assign y_out     = yo_q;
`ifdef P2A_ZERO_CHECK_EN
    assign zero_z    = zo_q;
`else
    assign zero_z    = 1'b0;
`endif

endmodule
